// File: rtl/online_fir_pkg.sv
// Shared widths and default coefficient set for the streaming FIR filter.
package online_fir_pkg;

    localparam int unsigned FIR_DATA_WIDTH = 16;
    localparam int unsigned FIR_COEF_WIDTH = 16;
    localparam int unsigned FIR_NUM_TAPS   = 8;
    localparam int unsigned FIR_OUT_WIDTH  = 40;

    typedef logic signed [FIR_COEF_WIDTH-1:0] fir_coef_t;

    // Symmetric low-pass kernel, DC gain 44; entry i multiplies x[n-i].
    localparam fir_coef_t FIR_COEFS [FIR_NUM_TAPS] = '{
        16'sd1, 16'sd3, 16'sd7, 16'sd11, 16'sd11, 16'sd7, 16'sd3, 16'sd1
    };

endpackage

// File: rtl/online_fir_filter_tap.sv
// One filter tap: a delay-line register (S1) feeding a registered multiplier (S2).
module fir_tap
    import online_fir_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FIR_DATA_WIDTH,
    parameter int unsigned COEF_WIDTH = FIR_COEF_WIDTH,
    parameter logic signed [COEF_WIDTH-1:0] COEF = '0
) (
    input  logic                                     clk,
    input  logic                                     nrst,
    input  logic                                     enable,
    input  logic signed [DATA_WIDTH-1:0]             x_i,
    output logic signed [DATA_WIDTH-1:0]             x_o,
    output logic signed [DATA_WIDTH+COEF_WIDTH-1:0]  prod_o
);

    localparam int unsigned ProdWidth = DATA_WIDTH + COEF_WIDTH;

    logic signed [DATA_WIDTH-1:0] x_q;
    logic signed [ProdWidth-1:0]  prod_d;
    logic signed [ProdWidth-1:0]  prod_q;

    // Full-precision signed product; operands are sign-extended before the multiply.
    assign prod_d = ProdWidth'(x_q) * ProdWidth'(COEF);

    // Delay register: shifts in the upstream sample on every enabled edge.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            x_q <= '0;
        end else if (enable) begin
            x_q <= x_i;
        end
    end

    // Product register: multiplies the sample held in this tap's delay register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            prod_q <= '0;
        end else if (enable) begin
            prod_q <= prod_d;
        end
    end

    assign x_o    = x_q;
    assign prod_o = prod_q;

endmodule

// File: rtl/online_fir_filter.sv
// Streaming fixed-coefficient FIR: tap chain (delay + multiply) and a registered adder tree.
// Latency is three enabled edges from sample capture to result on data_out.
module online_fir_filter
    import online_fir_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FIR_DATA_WIDTH,
    parameter int unsigned COEF_WIDTH = FIR_COEF_WIDTH,
    parameter int unsigned NUM_TAPS   = FIR_NUM_TAPS,
    parameter int unsigned OUT_WIDTH  = FIR_OUT_WIDTH
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         enable,
    input  logic signed [DATA_WIDTH-1:0] din_x,
    output logic signed [OUT_WIDTH-1:0]  data_out
);

    localparam int unsigned ProdWidth = DATA_WIDTH + COEF_WIDTH;

    // x_chain[i] holds x[n-i]; prod[i] holds c[i]*x[n-1-i] one enabled edge later.
    logic signed [DATA_WIDTH-1:0] x_chain [NUM_TAPS];
    logic signed [ProdWidth-1:0]  prod    [NUM_TAPS];

    logic signed [OUT_WIDTH-1:0]  sum_d;
    logic signed [OUT_WIDTH-1:0]  data_out_q;

    for (genvar i = 0; i < NUM_TAPS; i++) begin : g_tap
        if (i == 0) begin : g_head
            fir_tap #(
                .DATA_WIDTH (DATA_WIDTH),
                .COEF_WIDTH (COEF_WIDTH),
                .COEF       (FIR_COEFS[i])
            ) u_tap (
                .clk    (clk),
                .nrst   (nrst),
                .enable (enable),
                .x_i    (din_x),
                .x_o    (x_chain[i]),
                .prod_o (prod[i])
            );
        end else begin : g_body
            fir_tap #(
                .DATA_WIDTH (DATA_WIDTH),
                .COEF_WIDTH (COEF_WIDTH),
                .COEF       (FIR_COEFS[i])
            ) u_tap (
                .clk    (clk),
                .nrst   (nrst),
                .enable (enable),
                .x_i    (x_chain[i-1]),
                .x_o    (x_chain[i]),
                .prod_o (prod[i])
            );
        end
    end

    // Adder tree: sign-extend every product to the output width and sum them.
    always_comb begin
        sum_d = '0;
        for (int unsigned i = 0; i < NUM_TAPS; i++) begin
            sum_d = sum_d + OUT_WIDTH'(prod[i]);
        end
    end

    // Output register: captures the tree sum on enabled edges, holds otherwise.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            data_out_q <= '0;
        end else if (enable) begin
            data_out_q <= sum_d;
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_online_fir_filter.sv
// Self-checking bench: behavioural convolution model checked every cycle plus literal pins.
module tb_online_fir_filter;

    localparam longint COEFS [8] = '{1, 3, 7, 11, 11, 7, 3, 1};

    logic               clk = 1'b0;
    logic               nrst = 1'b0;
    logic               enable = 1'b0;
    logic signed [15:0] din_x = '0;
    logic signed [39:0] data_out;

    int checks = 0;
    int errors = 0;

    // Every sample accepted since the last reset, oldest first.
    longint hist [$];

    online_fir_filter dut (
        .clk      (clk),
        .nrst     (nrst),
        .enable   (enable),
        .din_x    (din_x),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    // Model of the delay line: remember accepted samples, forget everything on reset.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) hist.delete();
        else if (enable) hist.push_back(longint'(din_x));
    end

    // y for the sample accepted two enabled edges before the newest one.
    function automatic longint model_y();
        longint acc = 0;
        int n = hist.size() - 3;
        if (n < 0) return 0;
        for (int i = 0; i < 8; i++) begin
            if (n - i >= 0) acc += COEFS[i] * hist[n - i];
        end
        return acc;
    endfunction

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: data_out=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) check("model", data_out, model_y());

    // Drive one cycle of inputs; returns 1 time unit after the following falling edge.
    task automatic cyc(input logic signed [15:0] d, input logic en);
        din_x  = d;
        enable = en;
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        nrst = 1'b0;
        #1;
        check("async_clear", data_out, 0);
        cyc(16'sd0, 1'b0);
        nrst = 1'b1;
    endtask

    longint imp_exp [9] = '{1, 3, 7, 11, 11, 7, 3, 1, 0};
    longint step_exp [9] = '{1000, 4000, 11000, 22000, 33000, 40000, 43000, 44000, 44000};

    initial begin
        @(negedge clk);
        #1;

        // Reset held while the input toggles.
        nrst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc((k % 2) ? 16'sh7fff : 16'sh8000, 1'b1);
            check("reset_hold", data_out, 0);
        end
        nrst = 1'b1;

        // Impulse response.
        cyc(16'sd1, 1'b1);
        cyc(16'sd0, 1'b1);
        cyc(16'sd0, 1'b1);
        check("impulse_0", data_out, imp_exp[0]);
        for (int k = 1; k < 9; k++) begin
            cyc(16'sd0, 1'b1);
            check("impulse", data_out, imp_exp[k]);
        end

        // Impulse with a 4-cycle stall; garbage input while stalled must be ignored.
        pulse_reset();
        cyc(16'sd1, 1'b1);
        cyc(16'sd0, 1'b1);
        cyc(16'sd0, 1'b1);
        check("stall_pre0", data_out, 1);
        cyc(16'sd0, 1'b1);
        check("stall_pre1", data_out, 3);
        cyc(16'sd0, 1'b1);
        check("stall_pre2", data_out, 7);
        for (int k = 0; k < 4; k++) begin
            cyc(16'($urandom_range(1, 65535)), 1'b0);
            check("stall_hold", data_out, 7);
        end
        for (int k = 3; k < 9; k++) begin
            cyc(16'sd0, 1'b1);
            check("stall_post", data_out, imp_exp[k]);
        end

        // Step response.
        pulse_reset();
        for (int k = 0; k < 11; k++) begin
            cyc(16'sd1000, 1'b1);
            if (k >= 2) check("step", data_out, step_exp[k - 2]);
        end

        // Most negative input: settles at -32768*44, sign-extended to 40 bits.
        pulse_reset();
        for (int k = 0; k < 12; k++) cyc(16'sh8000, 1'b1);
        check("neg_settle", data_out, -64'sd1441792);
        check("neg_msbs", {56'd0, data_out[39:32]}, 64'sd255);

        // Alternating extremes, checked by the model.
        pulse_reset();
        for (int k = 0; k < 40; k++) cyc((k % 2) ? 16'sh8000 : 16'sh7fff, 1'b1);

        // Random samples with random enable gaps and one mid-stream reset.
        pulse_reset();
        begin
            int accepted = 0;
            int budget = 0;
            logic en;
            while (accepted < 512 && budget < 5000) begin
                budget++;
                en = ($urandom_range(0, 3) != 0);
                if (accepted == 256 && en) begin
                    pulse_reset();
                    accepted++;
                end else begin
                    cyc(16'($urandom), en);
                    if (en) accepted++;
                end
            end
            check("random_budget", 64'(accepted), 64'sd512);
        end
        for (int k = 0; k < 4; k++) cyc(16'sd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
